fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised fetch stage with a decoupled instruction-cache request/response interface and a DEPTH-entry in-order fetch queue. Sits between the PC/branch-redirect logic and decode. Generates sequential PCs and tolerates multi-cycle cache latency by reserving a queue slot per request. Flushes on redirect and discards in-flight responses that are now stale.

## Interface
Parameters:
- XLEN, 32, PC width.
- DEPTH, 4, queue entries; power of 2, ≥2.
- RESET_PC, 0, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- take_branch  in  1  redirect request; flushes the queue.
- branch_loc  in  XLEN  redirect target.
- cache_req_valid  out  1  request valid.
- cache_req_ready  in  1  cache accepts the request.
- pc_to_cache  out  XLEN  request address.
- cache_rsp_valid  in  1  response valid; responses arrive in order, at least 1 cycle after acceptance.
- instr_from_cache  in  32  response instruction.
- instr_to_decode  out  32  head instruction.
- pc_to_decode  out  XLEN  head PC.
- valid  out  1  head entry filled and presentable.
- ready  in  1  decode accepts the head.
- fq_count  out  $clog2(DEPTH+1)  number of allocated entries.

## Operation
- State:
  - fetch_pc.
  - Circular queue of DEPTH entries {pc, instr, filled}.
  - head, tail and fill pointers, log2(DEPTH) bits, wrapping modulo DEPTH.
  - count.
  - drop_cnt, $clog2(DEPTH+1) bits.
- **Request:** cache_req_valid = ~take_branch & (count + drop_cnt < DEPTH). pc_to_cache = fetch_pc.
- **Accept** (cache_req_valid & cache_req_ready):
  - Write entry[tail] = {fetch_pc, –, filled=0}.
  - tail++, count++.
  - fetch_pc += 4, mod 2^XLEN; the addition wraps.
- **Response** (cache_rsp_valid):
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise, if an unfilled entry exists: entry[fill].instr = instr_from_cache, filled=1, fill++.
  - Otherwise: protocol error; ignore the response.
- **Output:**
  - valid = entry[head].filled & (count>0) & ~take_branch.
  - instr_to_decode and pc_to_decode = entry[head] fields.
- **Dequeue** (valid & ready): clear filled, head++, count--.
- Simultaneous accept and dequeue: count unchanged.
- The capacity check uses the current count. A slot freed by a dequeue becomes usable the next cycle.
- **Redirect** (take_branch=1) takes priority over everything:
  - No request, no dequeue.
  - All entries invalidated; head = tail = fill = 0; count = 0.
  - fetch_pc = branch_loc.
  - drop_cnt_next = drop_cnt + (unfilled entries) − (cache_rsp_valid ? 1 : 0). A response arriving in the redirect cycle is always discarded.
  - Back-to-back redirects: the last one wins, and drop_cnt accumulates.
- A response arriving in the same cycle as an accept may fill an older entry. It never fills the entry being allocated in that cycle.

## Timing
- **Reset (reset_n=0), asynchronous:**
  - fetch_pc = RESET_PC.
  - Pointers, count and drop_cnt = 0.
  - All entries zeroed.
  - valid = 0, cache_req_valid = 0, instr_to_decode = 0, pc_to_decode = 0, fq_count = 0, pc_to_cache = RESET_PC.
- First request is presented in the first cycle after reset_n deasserts.
- **Latency:** request accepted in cycle t; response in cycle t+L; valid=1 in cycle t+L+1.
- **Throughput:** DEPTH≥4 with L=1 and ready=1 sustains one instruction per cycle after fill-up.
- cache_req_valid with cache_req_ready=0: pc_to_cache holds stable until accepted or until a redirect.
- ready=0: head is held. Requests continue until count+drop_cnt=DEPTH, then stop.
- Redirect to target T in cycle r:
  - First request pc_to_cache=T in cycle r+1, when capacity allows.
  - No stale instruction is ever presented after cycle r.
- reset_n asserted mid-operation: state clears immediately. Responses still in flight at the cache are the cache's responsibility to squash; drop_cnt is not preserved.

## Test plan
- **Reset then stream** (L=1, ready=1, DEPTH=4): pc_to_cache = 0,4,8,…; decode sees pc 0,4,8 with matching instrs on consecutive cycles from cycle 3; fq_count ≤3.
- **Backpressure:** ready=0 for 10 cycles → 4 requests accepted (pcs 0–C), cache_req_valid=0, fq_count=4; ready=1 → pcs 0,4,8,C drained in order, fetching resumes at 0x10.
- **Cache stall:** cache_req_ready=0 for 3 cycles at pc 0x8 → pc_to_cache stays 0x8; no duplicate or skipped PC at decode.
- **Redirect with in-flight responses** (L=3): 3 outstanding, take_branch with branch_loc=0x100 → 3 following responses dropped; decode next sees pc 0x100, then 0x104.
- **Redirect coincident with a response**, plus back-to-back redirects (0x200 then 0x300): the coincident response is discarded; first decoded pc is 0x300; drop_cnt returns to 0.
- **Wrap and reset:** branch_loc=0xFFFF_FFFC → decode pcs FFFF_FFFC then 0x0; reset_n asserted mid-stream → valid=0 and fq_count=0 immediately; restart at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch stage: sequential PC generator with a decoupled I-cache request/response
// path and a DEPTH-entry in-order queue that reserves a slot per accepted request.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       take_branch,
  input  logic [XLEN-1:0]            branch_loc,
  output logic                       cache_req_valid,
  input  logic                       cache_req_ready,
  output logic [XLEN-1:0]            pc_to_cache,
  input  logic                       cache_rsp_valid,
  input  logic [31:0]                instr_from_cache,
  output logic [31:0]                instr_to_decode,
  output logic [XLEN-1:0]            pc_to_decode,
  output logic                       valid,
  input  logic                       ready,
  output logic [$clog2(DEPTH+1)-1:0] fq_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0]   PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]   PTR_ONE  = PW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_CAP  = CW'(DEPTH);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);

  logic [XLEN-1:0]  fetch_pc_r;
  logic [XLEN-1:0]  pc_mem_r    [DEPTH];
  logic [31:0]      instr_mem_r [DEPTH];
  logic [DEPTH-1:0] filled_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [PW-1:0]    fill_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    pending_r;
  logic [CW-1:0]    drop_cnt_r;

  logic [CW-1:0]    occupancy_s;
  logic [CW-1:0]    drop_sum_s;
  logic [CW-1:0]    redirect_drop_s;
  logic             accept_s;
  logic             dequeue_s;
  logic             rsp_drop_s;
  logic             rsp_fill_s;

  // Slots owed to stale in-flight responses count against capacity, so count+drop never exceeds DEPTH.
  assign occupancy_s     = count_r + drop_cnt_r;
  assign cache_req_valid = reset_n & ~take_branch & (occupancy_s < CNT_CAP);
  assign pc_to_cache     = fetch_pc_r;
  assign accept_s        = cache_req_valid & cache_req_ready;

  assign valid           = filled_r[head_r] & (count_r != CNT_ZERO) & ~take_branch;
  assign dequeue_s       = valid & ready;
  assign instr_to_decode = instr_mem_r[head_r];
  assign pc_to_decode    = pc_mem_r[head_r];
  assign fq_count        = count_r;

  assign rsp_drop_s      = cache_rsp_valid & (drop_cnt_r != CNT_ZERO);
  assign rsp_fill_s      = cache_rsp_valid & (drop_cnt_r == CNT_ZERO) & (pending_r != CNT_ZERO);
  assign drop_sum_s      = drop_cnt_r + pending_r;

  // Stale-response debt after a redirect; a response in the redirect cycle is consumed here.
  always_comb begin
    redirect_drop_s = drop_sum_s;
    if (cache_rsp_valid && (drop_sum_s != CNT_ZERO)) begin
      redirect_drop_s = drop_sum_s - CNT_ONE;
    end else begin
      redirect_drop_s = drop_sum_s;
    end
  end

  // Queue storage, pointers, counters and fetch PC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc_r <= RESET_PC;
      filled_r   <= {DEPTH{1'b0}};
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      fill_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      pending_r  <= CNT_ZERO;
      drop_cnt_r <= CNT_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]    <= {XLEN{1'b0}};
        instr_mem_r[i] <= 32'h0000_0000;
      end
    end else if (take_branch) begin
      fetch_pc_r <= branch_loc;
      filled_r   <= {DEPTH{1'b0}};
      head_r     <= PTR_ZERO;
      tail_r     <= PTR_ZERO;
      fill_r     <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      pending_r  <= CNT_ZERO;
      drop_cnt_r <= redirect_drop_s;
    end else begin
      if (accept_s) begin
        pc_mem_r[tail_r] <= fetch_pc_r;
        tail_r           <= tail_r + PTR_ONE;
        fetch_pc_r       <= fetch_pc_r + PC_STEP;
      end
      // The fill pointer only ever targets an already-allocated slot, never the one at tail.
      if (rsp_fill_s) begin
        instr_mem_r[fill_r] <= instr_from_cache;
        filled_r[fill_r]    <= 1'b1;
        fill_r              <= fill_r + PTR_ONE;
      end
      if (rsp_drop_s) begin
        drop_cnt_r <= drop_cnt_r - CNT_ONE;
      end
      if (dequeue_s) begin
        filled_r[head_r] <= 1'b0;
        head_r           <= head_r + PTR_ONE;
      end
      case ({accept_s, dequeue_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      case ({accept_s, rsp_fill_s})
        2'b10:   pending_r <= pending_r + CNT_ONE;
        2'b01:   pending_r <= pending_r - CNT_ONE;
        default: pending_r <= pending_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against
// a queue-based reference model and a latency-modelling cache.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } ent_t;

  typedef struct packed {
    logic [31:0] pc;
    int          due;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset_n, take_branch, cache_req_ready, cache_rsp_valid, ready;
  logic [31:0] branch_loc, instr_from_cache;
  logic        cache_req_valid, valid;
  logic [31:0] pc_to_cache, instr_to_decode, pc_to_decode;
  logic [2:0]  fq_count;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .take_branch(take_branch), .branch_loc(branch_loc),
    .cache_req_valid(cache_req_valid), .cache_req_ready(cache_req_ready), .pc_to_cache(pc_to_cache),
    .cache_rsp_valid(cache_rsp_valid), .instr_from_cache(instr_from_cache),
    .instr_to_decode(instr_to_decode), .pc_to_decode(pc_to_decode), .valid(valid),
    .ready(ready), .fq_count(fq_count)
  );

  int n_vec = 0;
  int n_fail = 0;

  // Reference model: in-order queue of fetched entries, stale-response debt, next PC.
  ent_t        mq[$];
  int          m_drop;
  logic [31:0] m_fpc;
  // Cache model: accepted requests waiting for their response cycle.
  rsp_t        cq[$];
  int          cyc;
  int          lat;
  bit          lat_rand;
  // Knobs and logs.
  bit          k_br, k_crdy, k_ready, k_rsp_en;
  logic [31:0] k_loc;
  logic [31:0] dq_log[$];
  int          dq_cyc[$];
  logic [31:0] acc_log[$];
  int          max_cnt;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic knobs(input bit crdy, input bit rdy, input int l);
    k_br = 1'b0; k_loc = 32'h0; k_crdy = crdy; k_ready = rdy; k_rsp_en = 1'b1;
    lat = l; lat_rand = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; take_branch = 1'b0; cache_req_ready = 1'b0; cache_rsp_valid = 1'b0;
    ready = 1'b0; branch_loc = 32'h0; instr_from_cache = 32'h0;
    #1;
    chk("rst_valid", 64'(valid), 64'(0));
    chk("rst_fq_count", 64'(fq_count), 64'(0));
    chk("rst_req_valid", 64'(cache_req_valid), 64'(0));
    chk("rst_pc_to_cache", 64'(pc_to_cache), 64'(0));
    chk("rst_pc_to_decode", 64'(pc_to_decode), 64'(0));
    chk("rst_instr_to_decode", 64'(instr_to_decode), 64'(0));
    mq.delete(); cq.delete(); dq_log.delete(); dq_cyc.delete(); acc_log.delete();
    m_drop = 0; m_fpc = 32'h0; cyc = 0; max_cnt = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic step();
    logic        rsp, e_req, e_valid, acc, deq;
    logic [31:0] rpc;
    int          unf, idx, lp;
    ent_t        e;
    rsp_t        r;
    @(negedge clk);
    cyc++;
    rsp = (k_rsp_en && cq.size() > 0) ? (cq[0].due <= cyc) : 1'b0;
    rpc = rsp ? cq[0].pc : 32'h0;
    take_branch = k_br; branch_loc = k_loc; cache_req_ready = k_crdy; ready = k_ready;
    cache_rsp_valid = rsp;
    instr_from_cache = rsp ? instr_of(rpc) : $urandom();
    e_req   = !k_br && (mq.size() + m_drop < DEPTH);
    e_valid = !k_br && mq.size() > 0 && mq[0].filled;
    #1;
    chk("req_valid", 64'(cache_req_valid), 64'(e_req));
    chk("pc_to_cache", 64'(pc_to_cache), 64'(m_fpc));
    chk("valid", 64'(valid), 64'(e_valid));
    chk("fq_count", 64'(fq_count), 64'(mq.size()));
    if (e_valid) begin
      chk("pc_to_decode", 64'(pc_to_decode), 64'(mq[0].pc));
      chk("instr_to_decode", 64'(instr_to_decode), 64'(mq[0].instr));
    end
    if (mq.size() > max_cnt) max_cnt = mq.size();
    acc = e_req && k_crdy;
    deq = e_valid && k_ready;
    if (rsp) void'(cq.pop_front());
    if (k_br) begin
      unf = 0;
      foreach (mq[i]) if (!mq[i].filled) unf++;
      m_drop = m_drop + unf - (rsp ? 1 : 0);
      if (m_drop < 0) m_drop = 0;
      mq.delete();
      m_fpc = k_loc;
    end else begin
      if (rsp) begin
        if (m_drop > 0) begin
          m_drop--;
        end else begin
          idx = -1;
          foreach (mq[i]) if (idx < 0 && !mq[i].filled) idx = i;
          if (idx >= 0) begin
            e = mq[idx]; e.instr = instr_of(rpc); e.filled = 1'b1; mq[idx] = e;
          end
        end
      end
      if (deq) begin
        dq_log.push_back(mq[0].pc);
        dq_cyc.push_back(cyc);
        void'(mq.pop_front());
      end
      if (acc) begin
        e.pc = m_fpc; e.instr = 32'h0; e.filled = 1'b0;
        mq.push_back(e);
        acc_log.push_back(m_fpc);
        lp = lat_rand ? int'($urandom_range(4, 1)) : lat;
        r.pc = m_fpc; r.due = cyc + lp;
        cq.push_back(r);
        m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; take_branch = 1'b0; cache_req_ready = 1'b0; cache_rsp_valid = 1'b0;
    ready = 1'b0; branch_loc = 32'h0; instr_from_cache = 32'h0;
    knobs(1'b1, 1'b1, 1);

    // Reset then stream, L=1.
    do_reset();
    knobs(1'b1, 1'b1, 1);
    repeat (12) step();
    chk("stream_dq_count", 64'(dq_log.size() >= 8), 64'(1));
    for (int i = 0; i < 8; i++) begin
      chk("stream_pc", 64'(dq_log[i]), 64'(4 * i));
      chk("stream_cycle", 64'(dq_cyc[i]), 64'(3 + i));
    end
    chk("stream_max_count", 64'(max_cnt <= 3), 64'(1));

    // Backpressure.
    do_reset();
    knobs(1'b1, 1'b0, 1);
    repeat (10) step();
    chk("bp_fq_count", 64'(fq_count), 64'(4));
    chk("bp_req_valid", 64'(cache_req_valid), 64'(0));
    k_ready = 1'b1;
    repeat (8) step();
    for (int i = 0; i < 5; i++) chk("bp_drain_pc", 64'(dq_log[i]), 64'(4 * i));
    chk("bp_resume_pc", 64'(acc_log[4]), 64'(32'h10));

    // Cache stall at pc 0x8.
    do_reset();
    knobs(1'b1, 1'b1, 1);
    repeat (2) step();
    k_crdy = 1'b0;
    repeat (3) begin
      step();
      chk("stall_pc_hold", 64'(pc_to_cache), 64'(32'h8));
    end
    k_crdy = 1'b1;
    repeat (10) step();
    for (int i = 0; i < 6; i++) chk("stall_dq_pc", 64'(dq_log[i]), 64'(4 * i));

    // Redirect with three responses in flight, L=3.
    do_reset();
    knobs(1'b1, 1'b1, 3);
    k_rsp_en = 1'b0;
    repeat (3) step();
    k_br = 1'b1; k_loc = 32'h100;
    step();
    chk("redir_fq_count", 64'(fq_count), 64'(0));
    chk("redir_pc_to_cache", 64'(pc_to_cache), 64'(32'h100));
    k_br = 1'b0; k_rsp_en = 1'b1;
    repeat (14) step();
    chk("redir_first_pc", 64'(dq_log[0]), 64'(32'h100));
    chk("redir_second_pc", 64'(dq_log[1]), 64'(32'h104));
    chk("redir_req_after", 64'(acc_log[3]), 64'(32'h100));

    // Redirect coincident with a response, then back-to-back redirect.
    do_reset();
    knobs(1'b1, 1'b1, 2);
    repeat (2) step();
    k_br = 1'b1; k_loc = 32'h200;
    step();
    k_loc = 32'h300; k_rsp_en = 1'b0;
    step();
    chk("b2b_pc_to_cache", 64'(pc_to_cache), 64'(32'h300));
    k_br = 1'b0; k_rsp_en = 1'b1;
    repeat (8) step();
    chk("b2b_first_pc", 64'(dq_log[0]), 64'(32'h300));
    k_ready = 1'b0;
    repeat (10) step();
    chk("b2b_full_count", 64'(fq_count), 64'(4));

    // PC wrap, then reset mid-stream.
    do_reset();
    knobs(1'b1, 1'b1, 1);
    repeat (3) step();
    k_br = 1'b1; k_loc = 32'hFFFF_FFFC;
    step();
    k_br = 1'b0;
    repeat (6) step();
    chk("wrap_pc_a", 64'(dq_log[1]), 64'(32'hFFFF_FFFC));
    chk("wrap_pc_b", 64'(dq_log[2]), 64'(32'h0));
    do_reset();
    knobs(1'b1, 1'b1, 1);
    repeat (5) step();
    chk("restart_req_pc", 64'(acc_log[0]), 64'(32'h0));
    chk("restart_dq_pc", 64'(dq_log[0]), 64'(32'h0));
    chk("restart_dq_cycle", 64'(dq_cyc[0]), 64'(3));

    // Random traffic against the model.
    do_reset();
    knobs(1'b1, 1'b1, 1);
    lat_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      k_br     = ($urandom_range(19, 0) == 0);
      k_loc    = ($urandom_range(1, 0) == 1) ? 32'hFFFF_FFF4 : ($urandom() & 32'hFFFF_FFFC);
      k_crdy   = ($urandom_range(3, 0) != 0);
      k_ready  = ($urandom_range(3, 0) != 0);
      k_rsp_en = ($urandom_range(3, 0) != 0);
      if ($urandom_range(199, 0) == 0) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
